// File: rtl/ps2_seq_ctrl_pkg.sv
// Shared encodings and default sizing for the PS/2 key-sequence controller.
package ps2_ctrl_pkg;

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_WAIT_ENTER = 2'b01;
  localparam logic [1:0] ST_WAIT_DATA  = 2'b10;
  localparam logic [1:0] ST_DONE       = 2'b11;

  localparam int NUM_FIELDS_DEF = 3;
  localparam int IDX_W_DEF      = 2;

endpackage

// File: rtl/ps2_seq_ctrl_if.sv
// Key-strobe inputs and save/complete/abort outputs between the PS/2 decoder and the sequence controller.
interface ps2_seq_ctrl_if
  import ps2_ctrl_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
);

  logic             ctrl;
  logic             enter;
  logic             dato;
  logic             esc;
  logic             salvar;
  logic [IDX_W-1:0] field_idx;
  logic             datos_listos;
  logic             abortado;
  logic             busy;

  modport master (
    output ctrl, enter, dato, esc,
    input  salvar, field_idx, datos_listos, abortado, busy
  );

  modport slave (
    input  ctrl, enter, dato, esc,
    output salvar, field_idx, datos_listos, abortado, busy
  );

endinterface

// File: rtl/ps2_timeout_cnt.sv
// Saturating idle counter; expire flags the last idle cycle while enabled. TIMEOUT_CYCLES = 0 disables it.
module ps2_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || (TIMEOUT_CYCLES == 0)) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && en && (r_cnt == LAST);

endmodule

// File: rtl/ps2_seq_ctrl.sv
// Enforces ctrl -> {enter -> dato} x NUM_FIELDS, emitting save/complete/abort pulses one cycle after the strobe.
module ps2_seq_ctrl
  import ps2_ctrl_pkg::*;
#(
  parameter int NUM_FIELDS     = NUM_FIELDS_DEF,
  parameter int IDX_W          = IDX_W_DEF,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_W           = 24
) (
  input logic           clk,
  input logic           rst,
  ps2_seq_ctrl_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS);

  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic [IDX_W-1:0] r_fieldIdx;
  logic [IDX_W-1:0] w_fieldIdxNext;
  logic             r_salvar;
  logic             r_datosListos;
  logic             r_abortado;
  logic             r_busy;
  logic             w_salvar;
  logic             w_datosListos;
  logic             w_abort;
  logic             w_inWait;
  logic             w_anyStrobe;
  logic             w_expire;
  logic             w_toClr;

  assign w_inWait    = (r_state == ST_WAIT_ENTER) || (r_state == ST_WAIT_DATA);
  assign w_anyStrobe = bus.ctrl | bus.enter | bus.dato | bus.esc;
  assign w_toClr     = w_anyStrobe || (w_nextState != r_state);
  assign w_abort     = w_inWait && (bus.esc || (w_expire && !w_anyStrobe));

  ps2_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_toClr),
    .en     (w_inWait),
    .expire (w_expire)
  );

  // Abort outranks every key, so the save decision is only taken when no abort is pending.
  always_comb begin
    w_nextState    = r_state;
    w_fieldIdxNext = r_fieldIdx;
    w_salvar       = 1'b0;
    w_datosListos  = 1'b0;
    if (w_abort) begin
      w_nextState    = ST_IDLE;
      w_fieldIdxNext = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.ctrl) w_nextState = ST_WAIT_ENTER;
        end
        ST_WAIT_ENTER: begin
          if (bus.enter && (r_fieldIdx < LAST_IDX)) begin
            w_fieldIdxNext = r_fieldIdx + 1'b1;
            w_nextState    = ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (bus.dato) begin
            w_salvar    = 1'b1;
            w_nextState = (r_fieldIdx == LAST_IDX) ? ST_DONE : ST_WAIT_ENTER;
          end
        end
        default: begin
          w_datosListos  = 1'b1;
          w_fieldIdxNext = '0;
          w_nextState    = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_fieldIdx    <= '0;
      r_salvar      <= 1'b0;
      r_datosListos <= 1'b0;
      r_abortado    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_fieldIdx    <= w_fieldIdxNext;
      r_salvar      <= w_salvar;
      r_datosListos <= w_datosListos;
      r_abortado    <= w_abort;
      r_busy        <= (w_nextState != ST_IDLE);
    end
  end

  assign bus.salvar       = r_salvar;
  assign bus.field_idx    = r_fieldIdx;
  assign bus.datos_listos = r_datosListos;
  assign bus.abortado     = r_abortado;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_ps2_seq_ctrl.sv
// Directed bench: three controller instances (default, timeout disabled, single field) fed the same strobes.
module tb_ps2_seq_ctrl;

  // Strobe vectors {ctrl, enter, dato, esc}; observed vectors {salvar, field_idx[1:0], datos_listos, abortado, busy}.
  localparam logic [3:0] N = 4'b0000;
  localparam logic [3:0] C = 4'b1000;
  localparam logic [3:0] E = 4'b0100;
  localparam logic [3:0] D = 4'b0010;
  localparam logic [3:0] X = 4'b0001;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  ps2_seq_ctrl_if #(.IDX_W(2)) busMain ();
  ps2_seq_ctrl_if #(.IDX_W(2)) busNoTo ();
  ps2_seq_ctrl_if #(.IDX_W(2)) busOne ();

  ps2_seq_ctrl #(.NUM_FIELDS(3), .IDX_W(2), .TIMEOUT_CYCLES(8), .TO_W(24)) dutMain (
    .clk (clk), .rst (rst), .bus (busMain.slave)
  );
  ps2_seq_ctrl #(.NUM_FIELDS(3), .IDX_W(2), .TIMEOUT_CYCLES(0), .TO_W(24)) dutNoTo (
    .clk (clk), .rst (rst), .bus (busNoTo.slave)
  );
  ps2_seq_ctrl #(.NUM_FIELDS(1), .IDX_W(2), .TIMEOUT_CYCLES(8), .TO_W(24)) dutOne (
    .clk (clk), .rst (rst), .bus (busOne.slave)
  );

  wire [5:0] wMain = {busMain.salvar, busMain.field_idx, busMain.datos_listos, busMain.abortado, busMain.busy};
  wire [5:0] wNoTo = {busNoTo.salvar, busNoTo.field_idx, busNoTo.datos_listos, busNoTo.abortado, busNoTo.busy};
  wire [5:0] wOne  = {busOne.salvar, busOne.field_idx, busOne.datos_listos, busOne.abortado, busOne.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of strobes to every instance; returns on the following falling edge.
  task automatic applyStimulus(input logic [3:0] s);
    {busMain.ctrl, busMain.enter, busMain.dato, busMain.esc} = s;
    {busNoTo.ctrl, busNoTo.enter, busNoTo.dato, busNoTo.esc} = s;
    {busOne.ctrl, busOne.enter, busOne.dato, busOne.esc}     = s;
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(N);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(N);
    applyStimulus(N);
    checkCount++;
    if (wMain !== 6'b0) $display("[TB] FAIL reset_main got %b expected %b", wMain, 6'b0);
    else passCount++;
    checkCount++;
    if (wNoTo !== 6'b0) $display("[TB] FAIL reset_noto got %b expected %b", wNoTo, 6'b0);
    else passCount++;
    checkCount++;
    if (wOne !== 6'b0) $display("[TB] FAIL reset_one got %b expected %b", wOne, 6'b0);
    else passCount++;
    rst = 1'b0;
  endtask

  task automatic test_full_sequence();
    logic [3:0] stim [9];
    logic [5:0] expv [9];
    stim = '{C, E, D, E, D, E, D, N, N};
    expv = '{6'b0_00_0_0_1, 6'b0_01_0_0_1, 6'b1_01_0_0_1, 6'b0_10_0_0_1, 6'b1_10_0_0_1,
             6'b0_11_0_0_1, 6'b1_11_0_0_1, 6'b0_00_1_0_0, 6'b0_00_0_0_0};
    for (int k = 0; k < 9; k++) begin
      applyStimulus(stim[k]);
      checkCount++;
      if (wMain !== expv[k]) $display("[TB] FAIL full_seq step %0d got %b expected %b", k, wMain, expv[k]);
      else passCount++;
    end
  endtask

  task automatic test_ignored_keys();
    logic [3:0] stim [8];
    logic [5:0] expv [8];
    stim = '{D, C, C, E, E, D, X, N};
    expv = '{6'b0_00_0_0_0, 6'b0_00_0_0_1, 6'b0_00_0_0_1, 6'b0_01_0_0_1,
             6'b0_01_0_0_1, 6'b1_01_0_0_1, 6'b0_00_0_1_0, 6'b0_00_0_0_0};
    for (int k = 0; k < 8; k++) begin
      applyStimulus(stim[k]);
      checkCount++;
      if (wMain !== expv[k]) $display("[TB] FAIL ignored step %0d got %b expected %b", k, wMain, expv[k]);
      else passCount++;
    end
  endtask

  task automatic test_esc_abort();
    logic [3:0] stim [16];
    logic [5:0] expv [16];
    stim = '{C, E, D, E, D, X, N, C, E, D, E, D, E, D, N, N};
    expv = '{6'b0_00_0_0_1, 6'b0_01_0_0_1, 6'b1_01_0_0_1, 6'b0_10_0_0_1, 6'b1_10_0_0_1,
             6'b0_00_0_1_0, 6'b0_00_0_0_0, 6'b0_00_0_0_1, 6'b0_01_0_0_1, 6'b1_01_0_0_1,
             6'b0_10_0_0_1, 6'b1_10_0_0_1, 6'b0_11_0_0_1, 6'b1_11_0_0_1, 6'b0_00_1_0_0,
             6'b0_00_0_0_0};
    for (int k = 0; k < 16; k++) begin
      applyStimulus(stim[k]);
      checkCount++;
      if (wMain !== expv[k]) $display("[TB] FAIL esc_abort step %0d got %b expected %b", k, wMain, expv[k]);
      else passCount++;
    end
  endtask

  task automatic test_timeout();
    applyStimulus(C);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(N);
      checkCount++;
      if (wMain !== ((k == 8) ? 6'b0_00_0_1_0 : 6'b0_00_0_0_1))
        $display("[TB] FAIL timeout idle %0d got %b", k, wMain);
      else passCount++;
    end
    applyStimulus(C);
    for (int k = 1; k <= 6; k++) applyStimulus(N);
    applyStimulus(C);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(N);
      checkCount++;
      if (wMain !== ((k == 8) ? 6'b0_00_0_1_0 : 6'b0_00_0_0_1))
        $display("[TB] FAIL timeout_restart idle %0d got %b", k, wMain);
      else passCount++;
    end
    applyStimulus(N);
    checkCount++;
    if (wMain !== 6'b0) $display("[TB] FAIL timeout_after got %b expected %b", wMain, 6'b0);
    else passCount++;
  endtask

  task automatic test_simultaneous();
    logic [3:0] stim [7];
    logic [5:0] expv [7];
    stim = '{C, E, (D | X), N, C, (E | D), (E | D)};
    expv = '{6'b0_00_0_0_1, 6'b0_01_0_0_1, 6'b0_00_0_1_0, 6'b0_00_0_0_0,
             6'b0_00_0_0_1, 6'b0_01_0_0_1, 6'b1_01_0_0_1};
    for (int k = 0; k < 7; k++) begin
      applyStimulus(stim[k]);
      checkCount++;
      if (wMain !== expv[k]) $display("[TB] FAIL simultaneous step %0d got %b expected %b", k, wMain, expv[k]);
      else passCount++;
    end
    applyStimulus(X);
    applyStimulus(N);
  endtask

  task automatic test_timeout_disabled();
    doReset();
    applyStimulus(C);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(N);
      checkCount++;
      if (wNoTo !== 6'b0_00_0_0_1) $display("[TB] FAIL no_timeout idle %0d got %b", k, wNoTo);
      else passCount++;
    end
    applyStimulus(X);
    checkCount++;
    if (wNoTo !== 6'b0_00_0_1_0) $display("[TB] FAIL no_timeout_esc got %b expected %b", wNoTo, 6'b0_00_0_1_0);
    else passCount++;
  endtask

  task automatic test_async_reset();
    doReset();
    applyStimulus(C);
    applyStimulus(E);
    applyStimulus(D);
    applyStimulus(E);
    checkCount++;
    if (wMain !== 6'b0_10_0_0_1) $display("[TB] FAIL pre_reset got %b expected %b", wMain, 6'b0_10_0_0_1);
    else passCount++;
    {busMain.ctrl, busMain.enter, busMain.dato, busMain.esc} = D;
    #2 rst = 1'b1;
    #1;
    checkCount++;
    if (wMain !== 6'b0) $display("[TB] FAIL async_reset got %b expected %b", wMain, 6'b0);
    else passCount++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(N);
      checkCount++;
      if (wMain !== 6'b0) $display("[TB] FAIL post_reset %0d got %b expected %b", k, wMain, 6'b0);
      else passCount++;
    end
  endtask

  task automatic test_one_field();
    logic [3:0] stim [5];
    logic [5:0] expv [5];
    stim = '{C, E, D, N, N};
    expv = '{6'b0_00_0_0_1, 6'b0_01_0_0_1, 6'b1_01_0_0_1, 6'b0_00_1_0_0, 6'b0_00_0_0_0};
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(stim[k]);
      checkCount++;
      if (wOne !== expv[k]) $display("[TB] FAIL one_field step %0d got %b expected %b", k, wOne, expv[k]);
      else passCount++;
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    {busMain.ctrl, busMain.enter, busMain.dato, busMain.esc} = N;
    {busNoTo.ctrl, busNoTo.enter, busNoTo.dato, busNoTo.esc} = N;
    {busOne.ctrl, busOne.enter, busOne.dato, busOne.esc}     = N;
    test_reset();
    test_full_sequence();
    test_ignored_keys();
    test_esc_abort();
    test_timeout();
    test_simultaneous();
    test_timeout_disabled();
    test_async_reset();
    test_one_field();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
